// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Iteration counter width; a 1-bit floor keeps the vector legal for tiny widths.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module divider_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] r_i,
   input  logic             d_msb_i,
   input  logic [WIDTH-1:0] v_i,
   output logic [WIDTH-1:0] r_o,
   output logic             q_bit_o
);

   logic [WIDTH:0] t;
   logic [WIDTH:0] diff;

   assign t    = {r_i, d_msb_i};
   assign diff = t - {1'b0, v_i};

   // No borrow out of the trial subtraction means T >= V.
   assign q_bit_o = ~diff[WIDTH];
   assign r_o     = q_bit_o ? diff[WIDTH-1:0] : t[WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// Sequential unsigned divider, one restoring bit per clock, with
// valid/ready handshakes on the operand and result sides.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; a producer holds valid and data stable until that edge, and
// ready never depends combinationally on the same interface's valid.
module divider
   import divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output div_state_t       dbg_state_o
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_t       state_q;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] d_q;
   logic [WIDTH-1:0] v_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             dbz_q;
   logic             out_valid_q;

   logic [WIDTH-1:0] r_d;
   logic             q_bit;

   // The partial remainder is always below V, so WIDTH bits hold it; the
   // extra bit only exists transiently inside the step.
   divider_step #(.WIDTH(WIDTH)) u_step (
      .r_i     (r_q),
      .d_msb_i (d_q[WIDTH-1]),
      .v_i     (v_q),
      .r_o     (r_d),
      .q_bit_o (q_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         r_q         <= '0;
         d_q         <= '0;
         v_q         <= '0;
         count_q     <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  d_q     <= dividend;
                  v_q     <= divisor;
                  r_q     <= '0;
                  count_q <= '0;
                  if (divisor == '0) begin
                     quotient_q  <= '1;
                     remainder_q <= dividend;
                     dbz_q       <= 1'b1;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               // Quotient bits fill D from the LSB as dividend bits leave the MSB,
               // so after WIDTH steps D holds the quotient.
               r_q     <= r_d;
               d_q     <= {d_q[WIDTH-2:0], q_bit};
               count_q <= count_q + 1'b1;
               if (count_q == LAST) begin
                  quotient_q  <= {d_q[WIDTH-2:0], q_bit};
                  remainder_q <= r_d;
                  dbz_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = out_valid_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Sequential unsigned integer divider: accepts a dividend/divisor pair, produces quotient and remainder.
- Performs the inverse of the team's accumulating multiplier, one restoring-division bit per clock.
- Sits beside the multiplier in the arithmetic datapath.
- Valid/ready handshakes on both input and output, so it can be back-pressured by downstream logic.

Parameters:
- WIDTH, 8, operand, quotient and remainder width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  divider can accept operands
- dividend  input  WIDTH  unsigned numerator
- divisor  input  WIDTH  unsigned denominator
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  result came from divisor == 0

Behaviour:
- Reset: rst_n low asynchronously forces:
  - state to IDLE;
  - quotient, remainder, div_by_zero, out_valid and the iteration counter to 0.
  - in_ready = 1 while in reset.
- Reset mid-operation aborts the division and discards the result. No output pulse follows.
- in_ready is combinational: it is 1 exactly when state == IDLE.
- out_valid is registered: it is 1 exactly when state == DONE.
- State machine:
  - IDLE --(in_valid && in_ready, divisor != 0)--> CALC
  - IDLE --(in_valid && in_ready, divisor == 0)--> DONE
  - CALC --(count == WIDTH-1)--> DONE
  - DONE --(out_ready)--> IDLE
- Accept edge: capture dividend into shift register D, divisor into register V. Clear partial remainder R (WIDTH+1 bits), quotient Q and count.
- Each CALC cycle (one restoring step):
  - T = {R[WIDTH-1:0], D[WIDTH-1]}.
  - If T >= V: R = T - V and shift 1 into Q LSB. Otherwise R = T and shift 0 into Q LSB.
  - D shifts left by 1.
  - count increments.
- Final CALC edge: load quotient = Q, remainder = R[WIDTH-1:0], div_by_zero = 0.
- Latency: for divisor != 0, out_valid rises WIDTH cycles after the accept edge. For divisor == 0, it rises 1 cycle after.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero = 1.
- Results hold stable while out_valid && !out_ready.
- No new operand is accepted in DONE. The earliest next accept is the cycle after the out_ready handshake, because in_ready rises only once state returns to IDLE.
- in_valid is ignored in CALC and DONE. Operand inputs may change freely after the accept edge.
- Boundaries:
  - dividend < divisor gives Q = 0, remainder = dividend.
  - dividend == divisor gives Q = 1, remainder = 0.
  - divisor == 1 gives Q = dividend.
  - All-ones / all-ones gives Q = 1.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Decomposition:
- divider_pkg holds:
  - the state enum div_state_t {IDLE, CALC, DONE};
  - the function or constant for counter width, $clog2(WIDTH).
- One sub-module: divider_step. It is purely combinational and implements one restoring iteration.
  - Inputs: R, D MSB, V.
  - Outputs: next R, quotient bit.
  - The top instantiates it once and iterates it over time.

Test Plan:
- Reset: hold rst_n low with in_valid = 1 -> in_ready = 1, out_valid = 0, all results 0. No accept occurs.
- Basic (WIDTH = 8): 100 / 7 -> out_valid exactly 8 cycles after accept; quotient = 14, remainder = 2, div_by_zero = 0.
- Divide by zero: 37 / 0 -> out_valid 1 cycle after accept; quotient = 255, remainder = 37, div_by_zero = 1.
- Boundaries:
  - 5 / 9 -> Q = 0, R = 5.
  - 255 / 255 -> Q = 1, R = 0.
  - 255 / 1 -> Q = 255, R = 0.
- Back-pressure: 200 / 3 with out_ready low for 5 cycles -> results stay 66 / 2 and in_ready stays 0. Raising out_ready gives in_ready = 1 on the next cycle, and a back-to-back 9 / 4 then yields 2 / 1.
- Reset mid-operation: assert rst_n low 3 cycles into 250 / 6 -> immediate IDLE with outputs 0. A new 50 / 5 then completes correctly with Q = 10, R = 0.
